// File: rtl/bit_scan_iter_pkg.sv
// Shared GPGPU types used by the set-bit iterator and its bus interface.
//   scan_mode_e : iteration order captured with each mask
package bit_scan_iter_pkg;

    typedef enum logic {
        SCAN_LSB_FIRST = 1'b0,
        SCAN_MSB_FIRST = 1'b1
    } scan_mode_e;

endpackage

// File: rtl/bit_scan_iter_if.sv
// Mask-in / index-out handshake bundle for bit_scan_iter.
//   in_*  : mask producer side (valid/ready, mask, scan order)
//   out_* : index consumer side (valid/ready, index, last flag, pending count)
//   master: producer/consumer (bench or upstream logic)
//   slave : the iterator itself
interface bit_scan_iter_if #(
    parameter int unsigned WIDTH = 32
);
    import bit_scan_iter_pkg::*;

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_mask_i;
    scan_mode_e       in_mode_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [IDX_W-1:0] out_idx_o;
    logic             out_last_o;
    logic [CNT_W-1:0] out_left_o;

    modport master (
        output in_valid_i, in_mask_i, in_mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_idx_o, out_last_o, out_left_o
    );

    modport slave (
        input  in_valid_i, in_mask_i, in_mode_i, out_ready_i,
        output in_ready_o, out_valid_o, out_idx_o, out_last_o, out_left_o
    );

endinterface

// File: rtl/bit_scan_iter_zero_counter.sv
// Combinational zero counter.
//   data_i  : vector to examine
//   count_o : MODE 0 -> trailing zeros, MODE 1 -> leading zeros; WIDTH when empty
//   empty_o : data_i is all zero
module zero_counter #(
    parameter int unsigned WIDTH = 32,
    parameter bit          MODE  = 1'b0
) (
    input  logic [WIDTH-1:0]           data_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Walk away from the counted end; the last hit is the nearest set bit.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (MODE == 1'b0) begin
                if (data_i[WIDTH-1-k]) count_o = CNT_W'(WIDTH - 1 - k);
            end else begin
                if (data_i[k]) count_o = CNT_W'(WIDTH - 1 - k);
            end
        end
    end

    assign empty_o = ~|data_i;

endmodule

// File: rtl/bit_scan_iter.sv
// Sequential set-bit iterator: takes a WIDTH-bit mask and emits the index of
// each set bit, one per cycle, LSB-first or MSB-first per mask.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   flush_i : synchronous abort of the current mask (no done pulse)
//   bus     : mask input / index output handshakes (slave side)
//   done_o  : one-cycle registered pulse when a mask has fully drained
// Note: in SCAN, bus.in_ready_o depends combinationally on bus.out_ready_i so
// a new mask can load on the final beat of the current one.
module bit_scan_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    bit_scan_iter_if.slave  bus,
    output logic            done_o
);
    import bit_scan_iter_pkg::*;

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "bit_scan_iter: WIDTH must be >= 2");
    end
    if ($bits(bus.in_mask_i) != WIDTH) begin : g_bad_bus
        $fatal(1, "bit_scan_iter: interface WIDTH does not match module WIDTH");
    end

    typedef enum logic {IDLE, SCAN} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mask_q;
    scan_mode_e       mode_q;
    logic             done_q;

    logic [WIDTH-1:0] scan_vec;
    logic [CNT_W-1:0] tz;
    logic [CNT_W-1:0] left;
    logic [IDX_W-1:0] idx;
    logic             zc_empty;
    logic             valid;
    logic             last;
    logic             beat;
    logic             accept;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // MSB-first order is handled by reversing the mask so a single
    // trailing-zero counter serves both modes.
    always_comb begin
        scan_vec = mask_q;
        if (mode_q == SCAN_MSB_FIRST) begin
            for (int unsigned i = 0; i < WIDTH; i++) scan_vec[i] = mask_q[WIDTH-1-i];
        end
    end

    zero_counter #(
        .WIDTH (WIDTH),
        .MODE  (1'b0)
    ) u_tz (
        .data_i  (scan_vec),
        .count_o (tz),
        .empty_o (zc_empty)
    );

    assign idx    = (mode_q == SCAN_MSB_FIRST) ? IDX_W'(CNT_W'(WIDTH - 1) - tz) : IDX_W'(tz);
    assign left   = popcount(mask_q);
    assign last   = (mask_q & (mask_q - WIDTH'(1))) == '0;
    assign valid  = (state_q == SCAN);
    assign beat   = valid & bus.out_ready_i;
    assign accept = bus.in_valid_i & bus.in_ready_o;

    assign bus.in_ready_o  = ~rst_i & ~flush_i & ((state_q == IDLE) | (beat & last));
    assign bus.out_valid_o = valid;
    assign bus.out_idx_o   = valid ? idx : '0;
    assign bus.out_last_o  = valid & last;
    assign bus.out_left_o  = valid ? left : '0;
    assign done_o          = done_q;

    // Beat retirement is applied first so a mask accepted on the final beat
    // overrides the return to IDLE; both completions share one done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            mode_q  <= SCAN_LSB_FIRST;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
                mask_q  <= '0;
            end else begin
                if (beat) begin
                    mask_q <= mask_q & ~(WIDTH'(1) << idx);
                    if (last) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                if (accept) begin
                    if (|bus.in_mask_i) begin
                        mask_q  <= bus.in_mask_i;
                        mode_q  <= bus.in_mode_i;
                        state_q <= SCAN;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

    a_scan_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == SCAN) |-> !zc_empty);

endmodule
